// File: rtl/emif_dpram_bank.sv
// EMIF storage bank: decodes EMIF word addresses onto a dual-port buffer RAM
// shared with user logic, a doorbell mailbox with interrupt, and a status
// register. Read data returns with a fixed two-cycle latency after the
// request edge. Access and error counters are kept for debug.
module emif_dpram_bank #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [23:0] MBX_ADDR  = 24'h000400,
    parameter logic [23:0] STAT_ADDR = 24'h000401,
    parameter logic [15:0] ERR_DATA  = 16'hDEAD
) (
    input  logic              clk_100m,
    input  logic              rst,
    input  logic              emif_dpram_wen,
    input  logic              emif_dpram_ren,
    input  logic [23:0]       emif_dpram_addr,
    input  logic [15:0]       emif_dpram_wdata,
    output logic [15:0]       emif_rdata,
    output logic              emif_rdata_vld,
    input  logic [ADDR_W-1:0] usr_addr,
    input  logic              usr_wen,
    input  logic [15:0]       usr_wdata,
    output logic [15:0]       usr_rdata,
    input  logic              usr_irq_ack,
    output logic              doorbell_irq,
    output logic [15:0]       doorbell_val,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       err_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        TGT_BUF  = 2'd0,
        TGT_MBX  = 2'd1,
        TGT_STAT = 2'd2,
        TGT_ERR  = 2'd3
    } tgt_e;

    function automatic tgt_e decode(input logic [23:0] a);
        if ((a >> ADDR_W) == 24'd0) return TGT_BUF;
        if (a == MBX_ADDR)          return TGT_MBX;
        if (a == STAT_ADDR)         return TGT_STAT;
        return TGT_ERR;
    endfunction

    logic [15:0] mem_q [DEPTH];
    logic [15:0] usr_rdata_q;
    logic [15:0] ram_rd_q;

    // request edge detection; armed_q blocks a level held high across reset
    logic ren_q, ren_d;
    logic armed_q, armed_d;

    // read pipeline: stage 1 holds the accepted request, stage 2 the selected data
    logic              rd_v1_q, rd_v1_d;
    tgt_e              rd_tgt1_q, rd_tgt1_d;
    logic [ADDR_W-1:0] rd_addr1_q, rd_addr1_d;
    logic              rd_v2_q, rd_v2_d;
    tgt_e              rd_tgt2_q, rd_tgt2_d;
    logic [15:0]       reg_rd_q, reg_rd_d;

    logic [15:0] emif_rdata_q, emif_rdata_d;
    logic        emif_rdata_vld_q, emif_rdata_vld_d;
    logic        doorbell_irq_q, doorbell_irq_d;
    logic [15:0] doorbell_val_q, doorbell_val_d;
    logic        overrun_q, overrun_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    tgt_e emif_tgt;
    logic rd_req;
    logic emif_buf_we;
    logic mbx_we;
    logic wr_err;
    logic rd_err;
    logic ovr_set;
    logic stat_rd;

    // strobe decode shared by the write path and the read request
    always_comb begin
        emif_tgt    = decode(emif_dpram_addr);
        rd_req      = emif_dpram_ren & ~ren_q & armed_q;
        emif_buf_we = emif_dpram_wen & ~rst & (emif_tgt == TGT_BUF);
        mbx_we      = emif_dpram_wen & (emif_tgt == TGT_MBX);
        wr_err      = emif_dpram_wen & (emif_tgt == TGT_ERR);
        rd_err      = rd_req & (emif_tgt == TGT_ERR);
        // an ack in the same cycle as a mailbox write means the previous doorbell was consumed
        ovr_set     = mbx_we & doorbell_irq_q & ~usr_irq_ack;
        stat_rd     = rd_v1_q & (rd_tgt1_q == TGT_STAT);
    end

    // next-state for control registers, read pipeline and counters
    always_comb begin
        ren_d   = emif_dpram_ren;
        armed_d = armed_q | ~emif_dpram_ren;

        rd_v1_d    = rd_req;
        rd_tgt1_d  = rd_req ? emif_tgt : rd_tgt1_q;
        rd_addr1_d = rd_req ? emif_dpram_addr[ADDR_W-1:0] : rd_addr1_q;

        rd_v2_d   = rd_v1_q;
        rd_tgt2_d = rd_tgt1_q;
        reg_rd_d  = (rd_tgt1_q == TGT_MBX) ? doorbell_val_q
                                           : {14'd0, overrun_q, doorbell_irq_q};

        emif_rdata_d = emif_rdata_q;
        if (rd_v2_q) begin
            case (rd_tgt2_q)
                TGT_BUF: emif_rdata_d = ram_rd_q;
                TGT_ERR: emif_rdata_d = ERR_DATA;
                default: emif_rdata_d = reg_rd_q;
            endcase
        end
        emif_rdata_vld_d = rd_v2_q;

        doorbell_irq_d = doorbell_irq_q;
        if (usr_irq_ack) doorbell_irq_d = 1'b0;
        if (mbx_we)      doorbell_irq_d = 1'b1;
        doorbell_val_d = mbx_we ? emif_dpram_wdata : doorbell_val_q;

        // a fresh overrun beats the read-to-clear of the same cycle
        overrun_d = overrun_q;
        if (stat_rd) overrun_d = 1'b0;
        if (ovr_set) overrun_d = 1'b1;

        wr_cnt_d  = wr_cnt_q + {15'd0, emif_buf_we};
        rd_cnt_d  = rd_cnt_q + {15'd0, rd_req};
        err_cnt_d = err_cnt_q + {15'd0, wr_err} + {15'd0, rd_err};
    end

    // control state registers with synchronous reset
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            ren_q            <= 1'b0;
            armed_q          <= ~emif_dpram_ren;
            rd_v1_q          <= 1'b0;
            rd_tgt1_q        <= TGT_BUF;
            rd_addr1_q       <= '0;
            rd_v2_q          <= 1'b0;
            rd_tgt2_q        <= TGT_BUF;
            reg_rd_q         <= 16'd0;
            emif_rdata_q     <= 16'd0;
            emif_rdata_vld_q <= 1'b0;
            doorbell_irq_q   <= 1'b0;
            doorbell_val_q   <= 16'd0;
            overrun_q        <= 1'b0;
            wr_cnt_q         <= 16'd0;
            rd_cnt_q         <= 16'd0;
            err_cnt_q        <= 16'd0;
        end else begin
            ren_q            <= ren_d;
            armed_q          <= armed_d;
            rd_v1_q          <= rd_v1_d;
            rd_tgt1_q        <= rd_tgt1_d;
            rd_addr1_q       <= rd_addr1_d;
            rd_v2_q          <= rd_v2_d;
            rd_tgt2_q        <= rd_tgt2_d;
            reg_rd_q         <= reg_rd_d;
            emif_rdata_q     <= emif_rdata_d;
            emif_rdata_vld_q <= emif_rdata_vld_d;
            doorbell_irq_q   <= doorbell_irq_d;
            doorbell_val_q   <= doorbell_val_d;
            overrun_q        <= overrun_d;
            wr_cnt_q         <= wr_cnt_d;
            rd_cnt_q         <= rd_cnt_d;
            err_cnt_q        <= err_cnt_d;
        end
    end

    // buffer RAM: read-first on both ports, EMIF write wins an address collision
    always_ff @(posedge clk_100m) begin
        if (usr_wen && !(emif_buf_we && (usr_addr == emif_dpram_addr[ADDR_W-1:0])))
            mem_q[usr_addr] <= usr_wdata;
        if (emif_buf_we)
            mem_q[emif_dpram_addr[ADDR_W-1:0]] <= emif_dpram_wdata;
        usr_rdata_q <= mem_q[usr_addr];
        ram_rd_q    <= mem_q[rd_addr1_q];
    end

    assign emif_rdata     = emif_rdata_q;
    assign emif_rdata_vld = emif_rdata_vld_q;
    assign usr_rdata      = usr_rdata_q;
    assign doorbell_irq   = doorbell_irq_q;
    assign doorbell_val   = doorbell_val_q;
    assign wr_cnt         = wr_cnt_q;
    assign rd_cnt         = rd_cnt_q;
    assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_emif_dpram_bank.sv
// Testbench for emif_dpram_bank: directed scenarios, a table of single EMIF
// accesses, and a randomized run checked every cycle against a reference model.
module tb_emif_dpram_bank;

    localparam logic [23:0] MBX  = 24'h000400;
    localparam logic [23:0] STAT = 24'h000401;

    logic        clk_100m = 1'b0;
    logic        rst = 1'b0;
    logic        emif_dpram_wen = 1'b0;
    logic        emif_dpram_ren = 1'b0;
    logic [23:0] emif_dpram_addr = '0;
    logic [15:0] emif_dpram_wdata = '0;
    logic [15:0] emif_rdata;
    logic        emif_rdata_vld;
    logic [9:0]  usr_addr = '0;
    logic        usr_wen = 1'b0;
    logic [15:0] usr_wdata = '0;
    logic [15:0] usr_rdata;
    logic        usr_irq_ack = 1'b0;
    logic        doorbell_irq;
    logic [15:0] doorbell_val;
    logic [15:0] wr_cnt, rd_cnt, err_cnt;

    emif_dpram_bank dut (
        .clk_100m        (clk_100m),
        .rst             (rst),
        .emif_dpram_wen  (emif_dpram_wen),
        .emif_dpram_ren  (emif_dpram_ren),
        .emif_dpram_addr (emif_dpram_addr),
        .emif_dpram_wdata(emif_dpram_wdata),
        .emif_rdata      (emif_rdata),
        .emif_rdata_vld  (emif_rdata_vld),
        .usr_addr        (usr_addr),
        .usr_wen         (usr_wen),
        .usr_wdata       (usr_wdata),
        .usr_rdata       (usr_rdata),
        .usr_irq_ack     (usr_irq_ack),
        .doorbell_irq    (doorbell_irq),
        .doorbell_val    (doorbell_val),
        .wr_cnt          (wr_cnt),
        .rd_cnt          (rd_cnt),
        .err_cnt         (err_cnt)
    );

    always #5 clk_100m = ~clk_100m;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    // reference model state
    logic [15:0] m_mem [1024];
    logic        m_irq, m_ovr, m_vld, m_prev_ren, m_armed;
    logic [15:0] m_val, m_wr, m_rd, m_err, m_rdata, m_usr;
    // read requests in flight: accepted (awaiting data selection) and resolved (awaiting delivery)
    logic        m_p1, m_p2;
    logic [23:0] m_p1_addr;
    logic [15:0] m_p2_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [15:0] usr_old;
        logic        clr, set_ovr, is_buf;
        usr_old = m_mem[usr_addr];
        is_buf  = (emif_dpram_addr < 24'd1024);
        if (rst) begin
            m_irq = 0; m_ovr = 0; m_val = 0; m_wr = 0; m_rd = 0; m_err = 0;
            m_rdata = 0; m_vld = 0; m_p1 = 0; m_p2 = 0;
            m_prev_ren = 0; m_armed = !emif_dpram_ren;
        end else begin
            m_vld = m_p2;
            if (m_p2) m_rdata = m_p2_data;
            clr = 0;
            m_p2 = m_p1;
            if (m_p1) begin
                if (m_p1_addr < 24'd1024)  m_p2_data = m_mem[m_p1_addr[9:0]];
                else if (m_p1_addr == MBX) m_p2_data = m_val;
                else if (m_p1_addr == STAT) begin
                    m_p2_data = {14'd0, m_ovr, m_irq};
                    clr = 1;
                end else m_p2_data = 16'hDEAD;
            end
            m_p1 = 0;
            if (emif_dpram_ren && !m_prev_ren && m_armed) begin
                m_p1 = 1;
                m_p1_addr = emif_dpram_addr;
                m_rd++;
                if (!is_buf && emif_dpram_addr != MBX && emif_dpram_addr != STAT) m_err++;
            end
            set_ovr = 0;
            if (emif_dpram_wen) begin
                if (is_buf) m_wr++;
                else if (emif_dpram_addr == MBX) begin
                    set_ovr = m_irq && !usr_irq_ack;
                    m_val = emif_dpram_wdata;
                end else if (emif_dpram_addr != STAT) m_err++;
            end
            if (usr_irq_ack) m_irq = 0;
            if (emif_dpram_wen && emif_dpram_addr == MBX) m_irq = 1;
            if (clr) m_ovr = 0;
            if (set_ovr) m_ovr = 1;
            m_prev_ren = emif_dpram_ren;
            if (!emif_dpram_ren) m_armed = 1;
        end
        if (usr_wen) m_mem[usr_addr] = usr_wdata;
        if (!rst && emif_dpram_wen && is_buf) m_mem[emif_dpram_addr[9:0]] = emif_dpram_wdata;
        m_usr = usr_old;
    endtask

    task automatic compare_model();
        chk("rnd_vld",   {31'd0, emif_rdata_vld}, {31'd0, m_vld});
        chk("rnd_rdata", {16'd0, emif_rdata},     {16'd0, m_rdata});
        chk("rnd_irq",   {31'd0, doorbell_irq},   {31'd0, m_irq});
        chk("rnd_val",   {16'd0, doorbell_val},   {16'd0, m_val});
        chk("rnd_wrcnt", {16'd0, wr_cnt},         {16'd0, m_wr});
        chk("rnd_rdcnt", {16'd0, rd_cnt},         {16'd0, m_rd});
        chk("rnd_errcnt",{16'd0, err_cnt},        {16'd0, m_err});
        chk("rnd_usr",   {16'd0, usr_rdata},      {16'd0, m_usr});
    endtask

    // one clock: model follows the edge, outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk_100m);
        model_step();
        @(negedge clk_100m);
        if (chk_en) compare_model();
    endtask

    task automatic do_reset();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic emif_write(input logic [23:0] a, input logic [15:0] d);
        emif_dpram_addr = a; emif_dpram_wdata = d; emif_dpram_wen = 1;
        tick();
        emif_dpram_wen = 0;
    endtask

    // Raises ren and waits for vld. The request edge is the first posedge, so
    // a vld two cycles after it is seen on the third posedge.
    task automatic emif_read(input string name, input logic [23:0] a, output logic [15:0] d);
        int lat;
        lat = 0;
        d = 16'hxxxx;
        emif_dpram_addr = a; emif_dpram_ren = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (emif_rdata_vld) begin
                lat = i; d = emif_rdata; break;
            end
        end
        chk({name, "_lat"}, lat, 3);
        emif_dpram_ren = 0;
        tick();
    endtask

    typedef struct {
        bit          rd;
        logic [23:0] addr;
        logic [15:0] data;
        logic [15:0] exp_rdata;
        logic [15:0] exp_err;
    } vec_t;
    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int pulses;

        tbl[0]  = '{0, 24'h000000, 16'h0F0F, 16'h0000, 16'd0};
        tbl[1]  = '{0, 24'h0003FF, 16'h7777, 16'h0000, 16'd0};
        tbl[2]  = '{1, 24'h000000, 16'h0000, 16'h0F0F, 16'd0};
        tbl[3]  = '{1, 24'h0003FF, 16'h0000, 16'h7777, 16'd0};
        tbl[4]  = '{0, STAT,       16'hFFFF, 16'h0000, 16'd0};
        tbl[5]  = '{1, STAT,       16'h0000, 16'h0000, 16'd0};
        tbl[6]  = '{0, 24'h000402, 16'h5555, 16'h0000, 16'd1};
        tbl[7]  = '{1, 24'h000402, 16'h0000, 16'hDEAD, 16'd2};
        tbl[8]  = '{1, 24'hFFFFFF, 16'h0000, 16'hDEAD, 16'd3};
        tbl[9]  = '{0, MBX,        16'h0042, 16'h0000, 16'd3};
        tbl[10] = '{1, MBX,        16'h0000, 16'h0042, 16'd3};
        tbl[11] = '{1, STAT,       16'h0000, 16'h0001, 16'd3};

        @(negedge clk_100m);
        do_reset();
        chk("rst_rdata",  {16'd0, emif_rdata},   32'd0);
        chk("rst_vld",    {31'd0, emif_rdata_vld}, 32'd0);
        chk("rst_irq",    {31'd0, doorbell_irq}, 32'd0);
        chk("rst_val",    {16'd0, doorbell_val}, 32'd0);
        chk("rst_wrcnt",  {16'd0, wr_cnt},       32'd0);
        chk("rst_rdcnt",  {16'd0, rd_cnt},       32'd0);
        chk("rst_errcnt", {16'd0, err_cnt},      32'd0);

        // buffer round trip
        emif_write(24'd5, 16'h1234);
        emif_read("rt", 24'd5, d);
        chk("rt_data", {16'd0, d}, 32'h1234);
        chk("rt_wrcnt", {16'd0, wr_cnt}, 32'd1);
        chk("rt_rdcnt", {16'd0, rd_cnt}, 32'd1);
        usr_addr = 10'd5; tick();
        chk("rt_usr", {16'd0, usr_rdata}, 32'h1234);

        // held ren gives one request only
        do_reset();
        emif_dpram_addr = 24'd5; emif_dpram_ren = 1; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (emif_rdata_vld) begin pulses++; d = emif_rdata; end
        end
        chk("held_pulses", pulses, 1);
        chk("held_data", {16'd0, d}, 32'h1234);
        chk("held_rdcnt", {16'd0, rd_cnt}, 32'd1);
        emif_dpram_ren = 0; tick();
        emif_read("held2", 24'd5, d);
        chk("held2_rdcnt", {16'd0, rd_cnt}, 32'd2);

        // doorbell
        emif_write(MBX, 16'hA5A5);
        chk("db_irq", {31'd0, doorbell_irq}, 32'd1);
        chk("db_val", {16'd0, doorbell_val}, 32'hA5A5);
        emif_write(MBX, 16'h0001);
        emif_read("db_st1", STAT, d);
        chk("db_st1", {16'd0, d}, 32'h0003);
        emif_read("db_st2", STAT, d);
        chk("db_st2", {16'd0, d}, 32'h0001);
        usr_irq_ack = 1; tick(); usr_irq_ack = 0;
        chk("db_ack", {31'd0, doorbell_irq}, 32'd0);

        // ack and mailbox write together while pending
        emif_write(MBX, 16'h1234);
        usr_irq_ack = 1;
        emif_write(MBX, 16'h00FF);
        usr_irq_ack = 0;
        chk("co_irq", {31'd0, doorbell_irq}, 32'd1);
        chk("co_val", {16'd0, doorbell_val}, 32'h00FF);
        emif_read("co_st", STAT, d);
        chk("co_st", {16'd0, d}, 32'h0001);

        // write collision, then error read
        usr_addr = 10'd7; usr_wdata = 16'h1111; usr_wen = 1;
        emif_write(24'd7, 16'hBEEF);
        usr_wen = 0;
        tick();
        chk("col_usr", {16'd0, usr_rdata}, 32'hBEEF);
        emif_read("col", 24'd7, d);
        chk("col_emif", {16'd0, d}, 32'hBEEF);
        emif_read("err", 24'h800000, d);
        chk("err_data", {16'd0, d}, 32'hDEAD);
        chk("err_cnt", {16'd0, err_cnt}, 32'd1);

        // reset in the middle of a read
        emif_dpram_addr = 24'd5; emif_dpram_ren = 1; pulses = 0;
        tick();
        rst = 1; tick(); tick(); rst = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (emif_rdata_vld) pulses++;
        end
        chk("mid_pulses", pulses, 0);
        chk("mid_rdcnt", {16'd0, rd_cnt}, 32'd0);
        emif_dpram_ren = 0; tick();
        emif_read("mid_after", 24'd5, d);
        chk("mid_after_data", {16'd0, d}, 32'h1234);
        chk("mid_after_rdcnt", {16'd0, rd_cnt}, 32'd1);

        // table of single accesses from a clean state
        do_reset();
        foreach (tbl[i]) begin
            if (tbl[i].rd) begin
                emif_read($sformatf("tbl%0d", i), tbl[i].addr, d);
                chk($sformatf("tbl%0d_data", i), {16'd0, d}, {16'd0, tbl[i].exp_rdata});
            end else begin
                emif_write(tbl[i].addr, tbl[i].data);
            end
            chk($sformatf("tbl%0d_err", i), {16'd0, err_cnt}, {16'd0, tbl[i].exp_err});
        end

        // randomized run against the model; buffer addresses 0..15 are filled first
        do_reset();
        for (int i = 0; i < 16; i++) begin
            usr_addr = 10'(i); usr_wdata = 16'($urandom); usr_wen = 1;
            tick();
        end
        usr_wen = 0;
        tick();
        chk_en = 1;
        for (int c = 0; c < 3000; c++) begin
            int sel;
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 2) == 0) emif_dpram_ren = ~emif_dpram_ren;
            emif_dpram_wen = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)       emif_dpram_addr = 24'($urandom_range(0, 15));
            else if (sel == 6) emif_dpram_addr = MBX;
            else if (sel == 7) emif_dpram_addr = STAT;
            else               emif_dpram_addr = 24'h800000 | 24'($urandom_range(0, 255));
            emif_dpram_wdata = 16'($urandom);
            usr_addr    = 10'($urandom_range(0, 15));
            usr_wen     = ($urandom_range(0, 2) == 0);
            usr_wdata   = 16'($urandom);
            usr_irq_ack = ($urandom_range(0, 7) == 0);
            tick();
        end
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
